// File: rtl/jailbreak_hs_autosave.sv
// High-score autosave engine: periodically reads the high-score image one byte
// at a time, forms a Fletcher-16 checksum per scan, and once a changed checksum
// has been seen on consecutive scans issues a dataslot write so the host pulls
// the table back into its slot.
//
// Handshakes:
//   mem_rd / mem_rd_valid : mem_rd is a one-cycle request carrying mem_address.
//     Exactly one request is outstanding; the next request goes out the cycle
//     after mem_rd_valid. mem_rd_valid is only accepted in SCAN while a request
//     is outstanding, so stale or spurious returns are dropped.
//   target_dataslot_write / _ack / _done : write is a one-cycle command strobe.
//     ack accepts it, done (with err) completes it. Both waits are bounded by
//     ACK_TIMEOUT; an expired wait counts as a failed save.
module jailbreak_hs_autosave #(
  parameter int          HS_LENGTH     = 83,
  parameter logic [31:0] SCAN_INTERVAL = 32'd7400000,
  parameter int          STABLE_SCANS  = 2,
  parameter logic [31:0] ACK_TIMEOUT   = 32'd74000000,
  parameter logic [15:0] SLOT_ID       = 16'd2,
  parameter logic [31:0] BRIDGE_BASE   = 32'h10000000
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        enable,
  input  logic        force_save,
  output logic        mem_rd,
  output logic [6:0]  mem_address,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        target_dataslot_write,
  input  logic        target_dataslot_ack,
  input  logic        target_dataslot_done,
  input  logic [2:0]  target_dataslot_err,
  output logic [15:0] target_dataslot_id,
  output logic [31:0] target_dataslot_slotoffset,
  output logic [31:0] target_dataslot_bridgeaddr,
  output logic [31:0] target_dataslot_length,
  output logic        save_busy,
  output logic [7:0]  save_count,
  output logic [7:0]  fail_count,
  output logic [2:0]  dbg_state_o,
  output logic [15:0] dbg_sum_o
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_INT    = 3'd1,
    ST_SCAN        = 3'd2,
    ST_EVAL        = 3'd3,
    ST_START_WRITE = 3'd4,
    ST_WAIT_ACK    = 3'd5,
    ST_WAIT_DONE   = 3'd6
  } state_t;

  localparam logic [6:0]  LAST_ADDR = 7'(HS_LENGTH - 1);
  localparam logic [7:0]  STABLE_N  = 8'(STABLE_SCANS);
  localparam logic [31:0] INT_LOAD  = SCAN_INTERVAL - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] int_cnt_q, int_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [6:0]  addr_q, addr_d;
  logic        issue_q, issue_d;
  logic [7:0]  sum1_q, sum1_d, sum2_q, sum2_d;
  logic [15:0] saved_q, saved_d, pending_q, pending_d;
  logic        have_base_q, have_base_d;
  logic        force_pend_q, force_pend_d;
  logic [7:0]  stable_q, stable_d;
  logic [7:0]  save_cnt_q, save_cnt_d, fail_cnt_q, fail_cnt_d;

  logic [7:0]  sum1_new, sum2_new;
  logic [15:0] cur_sum;
  logic [7:0]  stable_new;
  logic        fin_ok, fin_fail;

  // (a + b) mod 255 for operands already below 255
  function automatic logic [7:0] add_mod255(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 9'd255) s = s - 9'd255;
    return s[7:0];
  endfunction

  assign sum1_new = add_mod255(sum1_q, mem_rd_data);
  assign sum2_new = add_mod255(sum2_q, sum1_new);
  assign cur_sum  = {sum2_q, sum1_q};

  // Next-state, datapath updates and strobes
  always_comb begin
    state_d      = state_q;
    int_cnt_d    = int_cnt_q;
    timer_d      = timer_q;
    addr_d       = addr_q;
    issue_d      = issue_q;
    sum1_d       = sum1_q;
    sum2_d       = sum2_q;
    saved_d      = saved_q;
    pending_d    = pending_q;
    have_base_d  = have_base_q;
    force_pend_d = force_pend_q;
    stable_d     = stable_q;
    save_cnt_d   = save_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    stable_new   = stable_q;
    fin_ok       = 1'b0;
    fin_fail     = 1'b0;
    mem_rd                = 1'b0;
    target_dataslot_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_WAIT_INT;
          int_cnt_d = INT_LOAD;
        end
      end
      ST_WAIT_INT: begin
        if (!enable) begin
          state_d     = ST_IDLE;
          have_base_d = 1'b0;
        end else if (int_cnt_q == 32'd0) begin
          state_d = ST_SCAN;
          addr_d  = 7'd0;
          sum1_d  = 8'd0;
          sum2_d  = 8'd0;
          issue_d = 1'b1;
        end else begin
          int_cnt_d = int_cnt_q - 32'd1;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d     = ST_IDLE;
          have_base_d = 1'b0;
          issue_d     = 1'b0;
        end else if (issue_q) begin
          mem_rd  = 1'b1;
          issue_d = 1'b0;
        end else if (mem_rd_valid) begin
          sum1_d = sum1_new;
          sum2_d = sum2_new;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_EVAL;
          end else begin
            addr_d  = addr_q + 7'd1;
            issue_d = 1'b1;
          end
        end
      end
      ST_EVAL: begin
        state_d   = ST_WAIT_INT;
        int_cnt_d = INT_LOAD;
        if (!have_base_q) begin
          // First scan after enabling only establishes what is already saved
          saved_d     = cur_sum;
          have_base_d = 1'b1;
        end else if (force_pend_q) begin
          pending_d = cur_sum;
          state_d   = ST_START_WRITE;
        end else if (cur_sum == saved_q) begin
          stable_d = 8'd0;
        end else begin
          if (cur_sum == pending_q && stable_q != 8'd0) begin
            stable_new = stable_q + 8'd1;
          end else begin
            pending_d  = cur_sum;
            stable_new = 8'd1;
          end
          stable_d = stable_new;
          if (stable_new == STABLE_N) state_d = ST_START_WRITE;
        end
      end
      ST_START_WRITE: begin
        target_dataslot_write = 1'b1;
        state_d = ST_WAIT_ACK;
        timer_d = ACK_TIMEOUT;
      end
      ST_WAIT_ACK: begin
        if (target_dataslot_ack && target_dataslot_done) begin
          fin_ok   = (target_dataslot_err == 3'd0);
          fin_fail = (target_dataslot_err != 3'd0);
        end else if (target_dataslot_ack) begin
          state_d = ST_WAIT_DONE;
          timer_d = ACK_TIMEOUT;
        end else if (timer_q == 32'd0) begin
          fin_fail = 1'b1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (target_dataslot_done) begin
          fin_ok   = (target_dataslot_err == 3'd0);
          fin_fail = (target_dataslot_err != 3'd0);
        end else if (timer_q == 32'd0) begin
          fin_fail = 1'b1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A finished or abandoned command always returns to the scan cadence;
    // a failed save leaves saved_q alone so the same change is retried.
    if (fin_ok || fin_fail) begin
      state_d   = ST_WAIT_INT;
      int_cnt_d = INT_LOAD;
      stable_d  = 8'd0;
      if (fin_ok) begin
        saved_d    = pending_q;
        save_cnt_d = (save_cnt_q == 8'hFF) ? save_cnt_q : save_cnt_q + 8'd1;
      end else begin
        fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
      end
    end

    // A force request arriving on the same cycle as a write launch is kept
    if (state_d == ST_START_WRITE && state_q != ST_START_WRITE) force_pend_d = 1'b0;
    if (force_save) force_pend_d = 1'b1;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      int_cnt_q    <= 32'd0;
      timer_q      <= 32'd0;
      addr_q       <= 7'd0;
      issue_q      <= 1'b0;
      sum1_q       <= 8'd0;
      sum2_q       <= 8'd0;
      saved_q      <= 16'd0;
      pending_q    <= 16'd0;
      have_base_q  <= 1'b0;
      force_pend_q <= 1'b0;
      stable_q     <= 8'd0;
      save_cnt_q   <= 8'd0;
      fail_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      int_cnt_q    <= int_cnt_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      issue_q      <= issue_d;
      sum1_q       <= sum1_d;
      sum2_q       <= sum2_d;
      saved_q      <= saved_d;
      pending_q    <= pending_d;
      have_base_q  <= have_base_d;
      force_pend_q <= force_pend_d;
      stable_q     <= stable_d;
      save_cnt_q   <= save_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign mem_address                = addr_q;
  assign target_dataslot_id         = SLOT_ID;
  assign target_dataslot_slotoffset = 32'd0;
  assign target_dataslot_bridgeaddr = BRIDGE_BASE;
  assign target_dataslot_length     = 32'(HS_LENGTH);
  assign save_busy  = (state_q == ST_START_WRITE) || (state_q == ST_WAIT_ACK) ||
                      (state_q == ST_WAIT_DONE);
  assign save_count = save_cnt_q;
  assign fail_count = fail_cnt_q;
  assign dbg_state_o = state_q;
  assign dbg_sum_o   = cur_sum;

endmodule

// File: tb/tb_jailbreak_hs_autosave.sv
// Bench for jailbreak_hs_autosave: byte RAM responder with random latency,
// host responder for the dataslot command, and a checksum/save-decision model
// built from the Fletcher-16 definition and the save rules.
module tb_jailbreak_hs_autosave;
  localparam int          HS_LEN   = 83;
  localparam logic [31:0] INTERVAL = 32'd40;
  localparam int          STABLE   = 2;
  localparam logic [31:0] ACK_TO   = 32'd60;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_INT = 3'd1, S_SCAN = 3'd2, S_EVAL = 3'd3;

  logic        clk = 1'b0;
  logic        reset, enable, force_save;
  logic        mem_rd;
  logic [6:0]  mem_address;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        wr;
  logic        ack, done;
  logic [2:0]  err;
  logic [15:0] slot_id;
  logic [31:0] slot_off, bridge, length;
  logic        save_busy;
  logic [7:0]  save_count, fail_count;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_sum;

  jailbreak_hs_autosave #(
    .HS_LENGTH(HS_LEN), .SCAN_INTERVAL(INTERVAL), .STABLE_SCANS(STABLE),
    .ACK_TIMEOUT(ACK_TO), .SLOT_ID(16'd2), .BRIDGE_BASE(32'h10000000)
  ) dut (
    .clk_74a(clk), .reset(reset), .enable(enable), .force_save(force_save),
    .mem_rd(mem_rd), .mem_address(mem_address),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .target_dataslot_write(wr), .target_dataslot_ack(ack),
    .target_dataslot_done(done), .target_dataslot_err(err),
    .target_dataslot_id(slot_id), .target_dataslot_slotoffset(slot_off),
    .target_dataslot_bridgeaddr(bridge), .target_dataslot_length(length),
    .save_busy(save_busy), .save_count(save_count), .fail_count(fail_count),
    .dbg_state_o(dbg_state), .dbg_sum_o(dbg_sum)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [7:0] ram [0:127];
  int   exp_addr = 0;
  int   host_mode = 0;          // 0 = respond, 1 = never ack
  logic [2:0] host_err = 3'd0;

  // Model state
  logic        m_have_base = 1'b0;
  logic        m_force = 1'b0;
  logic [15:0] m_saved = 16'd0;
  logic [15:0] m_pending = 16'd0;
  logic [15:0] run_q[$];        // changed checksums seen since last save/match
  logic [15:0] exp_q[$];        // expected checksum per scan
  int          m_save = 0;
  int          m_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Software Fletcher-16 over the current RAM image
  function automatic logic [15:0] fletcher();
    int s1 = 0;
    int s2 = 0;
    for (int i = 0; i < HS_LEN; i++) begin
      s1 = (s1 + int'(ram[i])) % 255;
      s2 = (s2 + s1) % 255;
    end
    return {8'(s2), 8'(s1)};
  endfunction

  // Save decision for one finished scan: 1 when a write must be issued
  function automatic bit model_eval(input logic [15:0] cur);
    bit same;
    if (!m_have_base) begin
      m_saved = cur;
      m_have_base = 1'b1;
      return 1'b0;
    end
    if (m_force) begin
      m_force = 1'b0;
      m_pending = cur;
      return 1'b1;
    end
    if (cur == m_saved) begin
      run_q.delete();
      return 1'b0;
    end
    run_q.push_back(cur);
    if (run_q.size() < STABLE) return 1'b0;
    same = 1'b1;
    for (int i = run_q.size() - STABLE; i < run_q.size(); i++)
      if (run_q[i] != cur) same = 1'b0;
    if (same) m_pending = cur;
    return same;
  endfunction

  // ---------------- byte RAM responder ----------------
  always @(negedge clk) begin
    if (mem_rd === 1'b1 && reset === 1'b0) begin
      logic [6:0] a;
      int n;
      a = mem_address;
      chk("rd_addr", 32'(a), 32'(exp_addr));
      exp_addr = (exp_addr == HS_LEN - 1) ? 0 : exp_addr + 1;
      n = $urandom_range(0, 2);
      @(posedge clk);
      repeat (n) @(posedge clk);
      #1;
      mem_rd_valid = 1'b1;
      mem_rd_data  = ram[a];
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      mem_rd_data  = 8'($urandom);
    end
  end

  // ---------------- host responder and write monitor ----------------
  always @(negedge clk) begin
    if (wr === 1'b1 && reset === 1'b0) begin
      wr_cnt++;
      chk("wr_id", 32'(slot_id), 32'd2);
      chk("wr_len", length, 32'd83);
      chk("wr_bridge", bridge, 32'h10000000);
      chk("wr_off", slot_off, 32'd0);
      if (host_mode == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 ack = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          done = 1'b1;
          err  = host_err;
          @(posedge clk);
          #1 ack = 1'b0; done = 1'b0; err = 3'd0;
        end else begin
          @(posedge clk);
          #1 ack = 1'b0;
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1 done = 1'b1; err = host_err;
          @(posedge clk);
          #1 done = 1'b0; err = 3'd0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (dbg_state == s) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  // Let one scan run to completion, then check checksum, write decision,
  // command outcome and counters against the model.
  task automatic scan_check(input string tag);
    bit   exp_wr;
    int   w0;
    logic [15:0] e;
    wait_state(S_EVAL, 3000, {tag, "_reach_eval"});
    exp_q.push_back(fletcher());
    e = exp_q.pop_front();
    chk({tag, "_sum"}, 32'(dbg_sum), 32'(e));
    exp_wr = model_eval(e);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    chk({tag, "_wr"}, 32'(wr_cnt - w0), 32'(exp_wr));
    if (exp_wr) begin
      bit idle_seen = 1'b0;
      for (int i = 0; i < 400 && !idle_seen; i++) begin
        @(negedge clk);
        if (save_busy == 1'b0) idle_seen = 1'b1;
      end
      chk({tag, "_busy_end"}, 32'(idle_seen), 32'd1);
      if (host_mode == 1 || host_err != 3'd0) m_fail++;
      else begin
        m_saved = m_pending;
        m_save++;
      end
      run_q.delete();
    end
    chk({tag, "_save_cnt"}, 32'(save_count), 32'(m_save));
    chk({tag, "_fail_cnt"}, 32'(fail_count), 32'(m_fail));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; force_save = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = 8'd0;
    ack = 1'b0; done = 1'b0; err = 3'd0;
    for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
    ram[16] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_busy", 32'(save_busy), 32'd0);
    chk("rst_save_cnt", 32'(save_count), 32'd0);
    chk("rst_fail_cnt", 32'(fail_count), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_enable", 32'(dbg_state), 32'(S_IDLE));
    enable = 1'b1;

    // 1: fixed RAM, baseline then no writes
    for (int k = 0; k < 5; k++) scan_check("t1_fixed");

    // 2: one byte changes, write after two stable scans
    ram[16] = 8'h05;
    for (int k = 0; k < 4; k++) scan_check("t2_change");

    // 3: ramp pattern, checksum vs software reference
    for (int i = 0; i < HS_LEN; i++) ram[i] = 8'(i);
    for (int k = 0; k < 2; k++) scan_check("t3_ramp");

    // 4: flipping value never stabilises
    for (int k = 0; k < 4; k++) begin
      ram[5] = (k % 2 == 0) ? 8'h55 : 8'hAA;
      scan_check("t4_flip");
    end

    // 5: host reports an error, retried on the next stable pair
    ram[40] = 8'($urandom_range(128, 255));
    host_err = 3'd1;
    scan_check("t5_err_a");
    scan_check("t5_err_b");
    host_err = 3'd0;
    scan_check("t5_retry_a");
    scan_check("t5_retry_b");

    // 6: host never acks -> timeout counted as failure
    ram[70] = ram[70] ^ 8'hFF;
    host_mode = 1;
    scan_check("t6_to_a");
    scan_check("t6_to_b");
    host_mode = 0;

    // force_save: next scan writes without a stable pair
    @(negedge clk);
    force_save = 1'b1;
    m_force = 1'b1;
    @(negedge clk);
    force_save = 1'b0;
    scan_check("t6_force");
    scan_check("t6_after_force");

    // enable drop in WAIT_INT: back to IDLE, next scan is a baseline
    enable = 1'b0;
    @(negedge clk);
    chk("en_drop_state", 32'(dbg_state), 32'(S_IDLE));
    enable = 1'b1;
    m_have_base = 1'b0;
    ram[3] = ram[3] + 8'd1;
    scan_check("en_rebase");

    // reset while a scan is in progress
    wait_state(S_SCAN, 500, "mid_scan_reach");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_addr", 32'(mem_address), 32'd0);
    chk("mid_rst_wr", 32'(wr), 32'd0);
    chk("mid_rst_busy", 32'(save_busy), 32'd0);
    chk("mid_rst_save_cnt", 32'(save_count), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", 32'(dbg_state), 32'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the sequence stalls somewhere unbounded
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
